axis_s2mm_packer: RTL
=====================

// Module: axis_s2mm_packer
// PURPOSE
//   Stream source for the AXI DMA S2MM channel. Packs IN_DW-bit words from role logic into
//   OUT_DW-bit AXI-Stream beats. Frames are software-armed: frame_len words per frame, with
//   m_axis_tlast on the final beat so the DMA closes each transfer. A short final beat
//   carries a partial tkeep.
// PARAMETERS
//   IN_DW    32  input word width in bits; multiple of 8
//   OUT_DW   64  output beat width in bits (AXI_DMA_S_DW); RATIO=OUT_DW/IN_DW, power of 2, >=1
//   LEN_W    16  width of frame_len
// PORTS
//   axi_clk         in   1          single clock for all logic
//   axi_rst_n       in   1          reset; synchronous, active-low
//   start           in   1          one-cycle frame arm request
//   frame_len       in   LEN_W      input words per frame; sampled on an accepted start
//   busy            out  1          frame in progress (state != IDLE)
//   frame_done      out  1          one-cycle pulse: tlast beat handshaken
//   frame_cnt       out  32         completed frames; wraps 0xFFFFFFFF->0
//   s_axis_tdata    in   IN_DW      input word
//   s_axis_tvalid   in   1          input word valid
//   s_axis_tready   out  1          input word accepted when tvalid&tready
//   m_axis_tdata    out  OUT_DW     packed beat to DMA S2MM
//   m_axis_tkeep    out  OUT_DW/8   byte enables of the beat
//   m_axis_tlast    out  1          final beat of the frame
//   m_axis_tvalid   out  1          beat valid
//   m_axis_tready   in   1          DMA accepts beat
// BEHAVIOUR
//   Reset (axi_rst_n=0 at a rising edge):
//     - state=IDLE; partial lane data is discarded; no tlast is emitted.
//     - All outputs and counters are 0, including frame_cnt and m_axis_tvalid.
//   FSM IDLE->RUN: start=1 && frame_len!=0. Latch remaining=frame_len and clear lane index.
//     - start in any other state is ignored.
//     - start with frame_len==0 is ignored: no pulse, no beat.
//   FSM RUN->DRAIN: the frame's last word is accepted.
//   FSM DRAIN->IDLE: the tlast beat is handshaken. Same cycle: frame_done=1, frame_cnt+1.
//   Packing:
//     - Word k of a beat goes to tdata[k*IN_DW +: IN_DW]; the first word is in the LSBs.
//     - A beat completes on lane RATIO-1 or on the frame's last word.
//     - In a partial beat, unfilled lanes have tdata=0 and tkeep=0.
//     - tkeep is all-ones on full beats.
//   s_axis_tready = (state==RUN) && (!completes || !m_axis_tvalid || m_axis_tready).
//     - completes means the current word would complete a beat.
//     - Non-completing words keep flowing into the lane accumulator while the output is stalled.
//     - s_axis_tready is 0 in IDLE and in DRAIN.
//   Output register:
//     - Loaded on the edge that accepts a beat's completing word; m_axis_tvalid=1 from the next cycle.
//     - Latency: 1 cycle from the completing word to the beat.
//     - Full throughput (1 word/cycle) when m_axis_tready=1.
//     - While tvalid=1 && tready=0: tdata/tkeep/tlast are held stable and tvalid never drops (AXIS rule).
//     - Simultaneous drain and load in one cycle is allowed, with no bubble.
//   remaining and the lane index update only on an input handshake.
//   frame_done is registered: it asserts in the cycle after the tlast handshake edge.
// TESTING
//   1. RATIO=2, frame_len=4, words 1,2,3,4, tready=1 -> beats 0x00000002_00000001, then
//      0x00000004_00000003 with tlast; tkeep=0xFF; one frame_done; frame_cnt=1.
//   2. frame_len=3, words 1..3 -> beat 2: tdata=0x00000000_00000003, tkeep=0x0F, tlast=1.
//   3. frame_len=8, tready=0 for 10 cycles after beat 1 -> beat 1 held stable; word 3 accepted;
//      word 4 stalled (s_axis_tready=0); after release, beats 2..4 in order with no loss.
//   4. start pulsed while busy, and start with frame_len=0 when idle -> both ignored; busy and
//      frame_cnt unchanged.
//   5. axi_rst_n=0 after 3 of 6 words -> next cycle busy=0, tvalid=0; a new frame_len=2 frame
//      yields a single beat of the new words only, with tlast.
//   6. Random tvalid/tready, 1000 frames, frame_len in 1..300 -> scoreboard matches data, tkeep,
//      and tlast; frame_cnt=1000.

Source files
------------

// File: rtl/axis_s2mm_packer_if.sv
// AXI-Stream bundle: data, byte enables, last marker and the valid/ready handshake.
interface axis_s2mm_packer_if #(
    parameter int DW = 32
) ();
    logic [DW-1:0]   tdata;
    logic [DW/8-1:0] tkeep;
    logic            tlast;
    logic            tvalid;
    logic            tready;

    modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_s2mm_packer.sv
// Packs IN_DW-bit words into OUT_DW-bit AXI-Stream beats for the DMA S2MM channel.
// Each software-armed frame carries frame_len words and ends on a tlast beat; a short
// final beat has zeroed data and tkeep in its unfilled lanes.
module axis_s2mm_packer #(
    parameter int IN_DW  = 32,
    parameter int OUT_DW = 64,
    parameter int LEN_W  = 16
) (
    input  logic             axi_clk,
    input  logic             axi_rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    output logic             busy,
    output logic             frame_done,
    output logic [31:0]      frame_cnt,
    axis_s2mm_packer_if.slave  s_axis,
    axis_s2mm_packer_if.master m_axis
);
    localparam int RATIO  = OUT_DW / IN_DW;
    localparam int IN_KW  = IN_DW / 8;
    localparam int OUT_KW = OUT_DW / 8;
    localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    // The top lane is never stored: a word landing there completes the beat directly.
    localparam int ACC_W  = (RATIO > 1) ? (RATIO - 1) * IN_DW : IN_DW;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    remaining_q, remaining_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [ACC_W-1:0]    acc_q;
    logic [OUT_DW-1:0]   out_data_q;
    logic [OUT_KW-1:0]   out_keep_q;
    logic                out_last_q;
    logic                out_valid_q;
    logic                done_q;
    logic [31:0]         cnt_q;

    logic                last_word;
    logic                completes;
    logic                s_ready;
    logic                in_hs;
    logic                tlast_hs;
    logic [OUT_DW-1:0]   beat_data;
    logic [OUT_KW-1:0]   beat_keep;
    logic                unused_in;

    // Input sideband is not meaningful for this stream; framing comes from frame_len.
    assign unused_in = ^{s_axis.tkeep, s_axis.tlast};

    // Handshake qualifiers: a completing word needs room in the output register.
    always_comb begin
        last_word = (remaining_q == LEN_W'(1));
        completes = last_word || (lane_q == LAST_LANE);
        s_ready   = (state_q == RUN) &&
                    (!completes || !out_valid_q || m_axis.tready);
        in_hs     = s_axis.tvalid && s_ready;
        tlast_hs  = out_valid_q && m_axis.tready && out_last_q;
    end

    // Assemble the candidate beat: stored lanes below, the live word at lane_q, zeros above.
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
        localparam logic [LANE_W-1:0] LANE = LANE_W'(gi);
        if (gi < RATIO - 1) begin : g_stored
            assign beat_data[gi*IN_DW +: IN_DW] =
                (lane_q == LANE) ? s_axis.tdata :
                (lane_q >  LANE) ? acc_q[gi*IN_DW +: IN_DW] : '0;
        end else begin : g_top
            assign beat_data[gi*IN_DW +: IN_DW] = (lane_q == LANE) ? s_axis.tdata : '0;
        end
        assign beat_keep[gi*IN_KW +: IN_KW] = (lane_q >= LANE) ? '1 : '0;
    end

    // Frame FSM next state plus word/lane bookkeeping, which moves only on input handshakes.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        lane_d      = lane_q;
        unique case (state_q)
            IDLE: begin
                if (start && (frame_len != '0)) begin
                    state_d     = RUN;
                    remaining_d = frame_len;
                    lane_d      = '0;
                end
            end
            RUN: begin
                if (in_hs) begin
                    remaining_d = remaining_q - LEN_W'(1);
                    lane_d      = completes ? '0 : lane_q + LANE_W'(1);
                    if (last_word) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (tlast_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and bookkeeping registers.
    always_ff @(posedge axi_clk) begin
        if (!axi_rst_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            lane_q      <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            lane_q      <= lane_d;
        end
    end

    // Lane accumulator: holds the non-completing words of the beat being built.
    always_ff @(posedge axi_clk) begin
        if (!axi_rst_n) begin
            acc_q <= '0;
        end else if (in_hs && !completes) begin
            acc_q[lane_q*IN_DW +: IN_DW] <= s_axis.tdata;
        end
    end

    // Output beat register: load on a completing word (even while draining), else drop on accept.
    always_ff @(posedge axi_clk) begin
        if (!axi_rst_n) begin
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (in_hs && completes) begin
            out_data_q  <= beat_data;
            out_keep_q  <= beat_keep;
            out_last_q  <= last_word;
            out_valid_q <= 1'b1;
        end else if (m_axis.tready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Frame completion pulse and wrapping completed-frame counter.
    always_ff @(posedge axi_clk) begin
        if (!axi_rst_n) begin
            done_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            done_q <= tlast_hs;
            if (tlast_hs) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    assign busy          = (state_q != IDLE);
    assign frame_done    = done_q;
    assign frame_cnt     = cnt_q;
    assign s_axis.tready = s_ready;
    assign m_axis.tdata  = out_data_q;
    assign m_axis.tkeep  = out_keep_q;
    assign m_axis.tlast  = out_last_q;
    assign m_axis.tvalid = out_valid_q;
endmodule
